// File: rtl/dma_fsm_unit.sv
`default_nettype none
// ============================================================================
// dma_fsm_unit : sequences 512-bit host cache lines to/from a 32-bit DMA port.
// Optional macro DMA_FSM_PERF_CNT_EN adds lines_in/lines_out counters. Rev 1.0
// ============================================================================
module dma_fsm_unit #(
   parameter int CL_SIZE_WIDTH = 512,
   parameter int WORD_SIZE     = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     empty,
   input  logic                     full,
   input  logic [CL_SIZE_WIDTH-1:0] dma_rd_data,
   output logic                     host_rd_ready,
   input  logic                     wr_ready,
   output logic [CL_SIZE_WIDTH-1:0] line_buffer,
   output logic                     host_wr_ready,
   output logic                     DMAEn,
   output logic                     DMAWrEn,
   output logic [31:0]              DMAAddr,
   output logic [WORD_SIZE-1:0]     data_to_mem,
   input  logic [WORD_SIZE-1:0]     data_to_host,
   input  logic                     DMAValid
`ifdef DMA_FSM_PERF_CNT_EN
   ,
   output logic [31:0]              lines_in,
   output logic [31:0]              lines_out
`endif
);

   localparam int WPL = CL_SIZE_WIDTH / WORD_SIZE;
   localparam int CW  = $clog2(WPL);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_WR    = 3'd2,
      S_RD    = 3'd3,
      S_RWAIT = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t                   state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [CW-1:0]            rx_q, rx_d;
   logic [27:0]              waddr_q, waddr_d;
   logic [27:0]              raddr_q, raddr_d;
   logic [CL_SIZE_WIDTH-1:0] line_q, line_d;
   logic [CL_SIZE_WIDTH-1:0] lbuf_q, lbuf_d;
   logic                     cnt_last, rx_last;

   assign cnt_last    = (cnt_q == CW'(WPL - 1));
   assign rx_last     = (rx_q == CW'(WPL - 1));
   assign line_buffer = lbuf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rx_q    <= '0;
         waddr_q <= '0;
         raddr_q <= '0;
         line_q  <= '0;
         lbuf_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rx_q    <= rx_d;
         waddr_q <= waddr_d;
         raddr_q <= raddr_d;
         line_q  <= line_d;
         lbuf_q  <= lbuf_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      rx_d          = rx_q;
      waddr_d       = waddr_q;
      raddr_d       = raddr_q;
      line_d        = line_q;
      lbuf_d        = lbuf_q;
      host_rd_ready = 1'b0;
      host_wr_ready = 1'b0;
      DMAEn         = 1'b0;
      DMAWrEn       = 1'b0;
      DMAAddr       = '0;
      data_to_mem   = '0;

      // Read responses trail requests by a cycle, so capture spans RD and RWAIT.
      if ((state_q == S_RD || state_q == S_RWAIT) && DMAValid) begin
         lbuf_d[int'(rx_q)*WORD_SIZE +: WORD_SIZE] = data_to_host;
         rx_d = rx_q + CW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               state_d = S_LOAD;
            end else if (wr_ready && !full) begin
               state_d = S_RD;
               cnt_d   = '0;
               rx_d    = '0;
            end
         end
         S_LOAD: begin
            host_rd_ready = 1'b1;
            line_d        = dma_rd_data;
            cnt_d         = '0;
            state_d       = S_WR;
         end
         S_WR: begin
            DMAEn       = 1'b1;
            DMAWrEn     = 1'b1;
            DMAAddr     = {4'h0, waddr_q};
            data_to_mem = line_q[int'(cnt_q)*WORD_SIZE +: WORD_SIZE];
            waddr_d     = waddr_q + 28'd1;
            cnt_d       = cnt_q + CW'(1);
            if (cnt_last) state_d = S_IDLE;
         end
         S_RD: begin
            DMAEn   = 1'b1;
            DMAAddr = {4'h0, raddr_q};
            raddr_d = raddr_q + 28'd1;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_last) state_d = S_RWAIT;
         end
         S_RWAIT: begin
            if (DMAValid && rx_last) state_d = S_DONE;
         end
         S_DONE: begin
            host_wr_ready = 1'b1;
            state_d       = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef DMA_FSM_PERF_CNT_EN
   logic [31:0] lines_in_q, lines_out_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lines_in_q  <= '0;
         lines_out_q <= '0;
      end else begin
         if (state_q == S_WR && cnt_last) lines_in_q  <= lines_in_q + 32'd1;
         if (state_q == S_DONE)           lines_out_q <= lines_out_q + 32'd1;
      end
   end

   assign lines_in  = lines_in_q;
   assign lines_out = lines_out_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dma_fsm_unit.sv
`default_nettype none
// Self-checking bench for dma_fsm_unit: directed and random host/memory line
// transfers compared against a transfer-level reference model.
module tb_dma_fsm_unit;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         empty;
   logic         full;
   logic [511:0] dma_rd_data;
   logic         host_rd_ready;
   logic         wr_ready;
   logic [511:0] line_buffer;
   logic         host_wr_ready;
   logic         DMAEn;
   logic         DMAWrEn;
   logic [31:0]  DMAAddr;
   logic [31:0]  data_to_mem;
   logic [31:0]  data_to_host;
   logic         DMAValid;
`ifdef DMA_FSM_PERF_CNT_EN
   logic [31:0]  lines_in;
   logic [31:0]  lines_out;
`endif

   dma_fsm_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .empty         (empty),
      .full          (full),
      .dma_rd_data   (dma_rd_data),
      .host_rd_ready (host_rd_ready),
      .wr_ready      (wr_ready),
      .line_buffer   (line_buffer),
      .host_wr_ready (host_wr_ready),
      .DMAEn         (DMAEn),
      .DMAWrEn       (DMAWrEn),
      .DMAAddr       (DMAAddr),
      .data_to_mem   (data_to_mem),
      .data_to_host  (data_to_host),
      .DMAValid      (DMAValid)
`ifdef DMA_FSM_PERF_CNT_EN
      ,
      .lines_in      (lines_in),
      .lines_out     (lines_out)
`endif
   );

   always #5 clk = ~clk;

   // Memory model: read data returned one cycle after the request.
   logic [31:0] rdmem [0:4095];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         DMAValid     <= 1'b0;
         data_to_host <= 32'h0;
      end else begin
         DMAValid     <= DMAEn && !DMAWrEn;
         data_to_host <= rdmem[DMAAddr[11:0]];
      end
   end

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [27:0] ref_waddr = 28'h0;
   logic [27:0] ref_raddr = 28'h0;
   int          ref_lines_in  = 0;
   int          ref_lines_out = 0;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_perf();
`ifdef DMA_FSM_PERF_CNT_EN
      chk("lines_in", 512'(lines_in), 512'(ref_lines_in));
      chk("lines_out", 512'(lines_out), 512'(ref_lines_out));
`endif
   endtask

   function automatic logic [511:0] rand_line();
      logic [511:0] l;
      for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
      return l;
   endfunction

   // Called at a negedge with the DUT idle; abort_at >= 0 pulls reset at that word.
   task automatic do_write(input logic [511:0] line, input int abort_at);
      dma_rd_data = line;
      empty       = 1'b0;
      @(negedge clk);
      chk("pop_pulse", 512'(host_rd_ready), 512'(1'b1));
      chk("pop_no_mem", 512'(DMAEn), 512'(1'b0));
      empty = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         chk("wr_ctrl", 512'({DMAEn, DMAWrEn, host_rd_ready}), 512'(3'b110));
         chk("wr_addr", 512'(DMAAddr), 512'({4'h0, ref_waddr}));
         chk("wr_data", 512'(data_to_mem), 512'(line[32*k +: 32]));
         ref_waddr = ref_waddr + 28'd1;
         if (k == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk("abort_outs", 512'({DMAEn, DMAWrEn, host_rd_ready, host_wr_ready, DMAAddr, data_to_mem}), 512'(0));
            chk("abort_lbuf", line_buffer, 512'(0));
            ref_waddr     = 28'h0;
            ref_raddr     = 28'h0;
            ref_lines_in  = 0;
            ref_lines_out = 0;
            @(negedge clk);
            chk("abort_hold", 512'(DMAEn), 512'(1'b0));
            rst_n = 1'b1;
            chk_perf();
            return;
         end
      end
      ref_lines_in++;
      @(negedge clk);
      chk("wr_end_idle", 512'({DMAEn, DMAWrEn}), 512'(2'b00));
      chk_perf();
   endtask

   // Called at a negedge with the DUT idle; wr_ready drops after request drop_at.
   task automatic do_read(input int drop_at);
      logic [27:0]  base;
      logic [511:0] exp_line;
      int           pulses;
      base     = ref_raddr;
      wr_ready = 1'b1;
      full     = 1'b0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         chk("rd_ctrl", 512'({DMAEn, DMAWrEn}), 512'(2'b10));
         chk("rd_addr", 512'(DMAAddr), 512'({4'h0, ref_raddr}));
         ref_raddr = ref_raddr + 28'd1;
         if (k == drop_at || k == 15) wr_ready = 1'b0;
      end
      for (int j = 0; j < 16; j++) exp_line[32*j +: 32] = rdmem[(int'(base) + j) & 4095];
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("rd_quiet", 512'(DMAEn), 512'(1'b0));
         if (host_wr_ready) begin
            pulses++;
            chk("rd_line", line_buffer, exp_line);
         end
      end
      chk("rd_pulses", 512'(pulses), 512'(1));
      chk("rd_line_hold", line_buffer, exp_line);
      ref_lines_out++;
      chk_perf();
   endtask

   initial begin
      logic [511:0] l;
      rst_n       = 1'b0;
      empty       = 1'b1;
      full        = 1'b0;
      wr_ready    = 1'b0;
      dma_rd_data = '0;
      for (int i = 0; i < 4096; i++) rdmem[i] = (i < 16) ? 32'(i) : $urandom;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_outs", 512'({DMAEn, DMAWrEn, host_rd_ready, host_wr_ready, DMAAddr, data_to_mem}), 512'(0));
      chk("rst_lbuf", line_buffer, 512'(0));
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("idle_outs", 512'({DMAEn, DMAWrEn, host_rd_ready, host_wr_ready, DMAAddr, data_to_mem}), 512'(0));
      end
      chk_perf();

      // Directed host->mem line: word i of the line holds 15-i.
      for (int i = 0; i < 16; i++) l[32*i +: 32] = 32'(15 - i);
      do_write(l, -1);

      // Directed mem->host line from addresses 0..15.
      do_read(-1);

      // Simultaneous requests: the host->mem line wins, the read follows.
      wr_ready = 1'b1;
      do_write(rand_line(), -1);
      do_read(5);

      // Write FIFO full blocks the read until it clears.
      full     = 1'b1;
      wr_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("full_blocks", 512'(DMAEn), 512'(1'b0));
      end
      do_read(-1);

      for (int it = 0; it < 6; it++) begin
         if ($urandom_range(0, 1) == 0) do_write(rand_line(), -1);
         else                           do_read(int'($urandom_range(0, 15)));
      end

      // Reset during the eighth written word, then restart from address 0.
      do_write(rand_line(), 7);
      do_write(rand_line(), -1);
      do_read(-1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
